// File: rtl/mem_dma.sv
// mem_dma: block copy / fill engine that drives the mem_data read and write ports.
// Words move through a two-stage read -> write pipeline, one word per cycle.
module mem_dma #(
    parameter int unsigned COUNT_LEN = 8,
    parameter int unsigned WORD_LEN  = 16,
    parameter int unsigned ADDR_LEN  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    input  logic [ADDR_LEN-1:0]  srcAddr,
    input  logic [ADDR_LEN-1:0]  dstAddr,
    input  logic [COUNT_LEN-1:0] len,
    input  logic [WORD_LEN-1:0]  fillData,
    output logic                 busy,
    output logic                 done,
    input  logic [WORD_LEN-1:0]  memDataOut,
    output logic [ADDR_LEN-1:0]  memReadAddr,
    output logic [ADDR_LEN-1:0]  memWriteAddr,
    output logic [WORD_LEN-1:0]  memDataIn,
    output logic                 memWriteEn
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    state_e               state_q, state_d;

    // Command arguments, frozen for the whole transfer.
    logic                 mode_q, mode_d;
    logic [ADDR_LEN-1:0]  src_q, src_d;
    logic [ADDR_LEN-1:0]  dst_q, dst_d;
    logic [COUNT_LEN-1:0] len_q, len_d;
    logic [WORD_LEN-1:0]  fill_q, fill_d;

    // Read-side word counter.
    logic [COUNT_LEN-1:0] rd_cnt_q, rd_cnt_d;

    // Write stage: data word, its destination address and a valid flag. The address is
    // captured together with the word (dst + index), so it always equals dst + wrCnt for
    // the write in flight and simply holds once the pipeline empties.
    logic [WORD_LEN-1:0]  stage_q, stage_d;
    logic [ADDR_LEN-1:0]  wr_addr_q, wr_addr_d;
    logic                 stage_valid_q, stage_valid_d;

    logic [ADDR_LEN-1:0]  rd_off;
    logic                 last_read;

    // Counter widened to address width; the sums below wrap modulo 2^ADDR_LEN.
    assign rd_off    = ADDR_LEN'(rd_cnt_q);
    assign last_read = (rd_cnt_q == len_q - COUNT_LEN'(1));

    // Next-state logic for the FSM and the datapath registers.
    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        src_d         = src_q;
        dst_d         = dst_q;
        len_d         = len_q;
        fill_d        = fill_q;
        rd_cnt_d      = rd_cnt_q;
        stage_d       = stage_q;
        wr_addr_d     = wr_addr_q;
        stage_valid_d = stage_valid_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d   = mode;
                    src_d    = srcAddr;
                    dst_d    = dstAddr;
                    len_d    = len;
                    fill_d   = fillData;
                    rd_cnt_d = '0;
                    // A zero-length command still spends one busy cycle (in DRAIN with an
                    // empty pipeline) so its done pulse lands one cycle after E1.
                    state_d  = (len == '0) ? StDrain : StRun;
                end
            end
            StRun: begin
                stage_d       = mode_q ? fill_q : memDataOut;
                wr_addr_d     = dst_q + rd_off;
                stage_valid_d = 1'b1;
                rd_cnt_d      = rd_cnt_q + COUNT_LEN'(1);
                if (last_read) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // The last word (if any) is written this cycle; the pipeline is then empty.
                stage_valid_d = 1'b0;
                state_d       = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            mode_q        <= 1'b0;
            src_q         <= '0;
            dst_q         <= '0;
            len_q         <= '0;
            fill_q        <= '0;
            rd_cnt_q      <= '0;
            stage_q       <= '0;
            wr_addr_q     <= '0;
            stage_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            src_q         <= src_d;
            dst_q         <= dst_d;
            len_q         <= len_d;
            fill_q        <= fill_d;
            rd_cnt_q      <= rd_cnt_d;
            stage_q       <= stage_d;
            wr_addr_q     <= wr_addr_d;
            stage_valid_q <= stage_valid_d;
        end
    end

    // Status and memory-port outputs, decoded from the registered state.
    always_comb begin
        busy         = (state_q == StRun) || (state_q == StDrain);
        done         = (state_q == StDone);
        memReadAddr  = (state_q == StRun) ? (src_q + rd_off) : '0;
        memWriteEn   = stage_valid_q;
        memWriteAddr = wr_addr_q;
        memDataIn    = stage_q;
    end

endmodule
